fta_respdemux128: RTL

Response demultiplexer that sits directly downstream of the merged 128-bit response buffer stage. It takes the single serialized response stream and steers each response, by channel-select bits in its transaction ID, to one of CHANNELS per-master output ports. Each output port has a small FIFO that absorbs bursts, because the upstream stage has no backpressure. Overflow is flagged rather than stalled.

---
 rtl/fta_respdemux128.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fta_respdemux128.sv
// fta_respdemux128 -- steers the merged 128-bit response stream to per-master
// output FIFOs, selected by a bit field of the transaction ID.
// The upstream stage cannot be stalled, so a full FIFO drops the response and
// raises a sticky overflow flag.
// Optional feature macro: FTA_RESPDEMUX_DROPCNT_EN adds a saturating 8-bit
// per-port drop counter on drop_cnt_o. When it is undefined, drop_cnt_o is 0.

package fta_pkg;
    typedef struct packed {
        logic         ack;
        logic         stall;
        logic         next;
        logic         err;
        logic         rty;
        logic [3:0]   pri;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;
endpackage

module fta_respdemux128
    import fta_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 4,
    parameter int SEL_LSB  = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  fta_cmd_response128_t                 resp_i,
    input  logic [CHANNELS-1:0]                  rdy_i,
    output fta_cmd_response128_t [CHANNELS-1:0]  resp_o,
    output logic [CHANNELS-1:0]                  ovf_o,
    output logic [CHANNELS-1:0][7:0]             drop_cnt_o
);

    localparam int SW = $clog2(CHANNELS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Reject unsupported configurations at elaboration time.
    if (!(CHANNELS == 2 || CHANNELS == 4 || CHANNELS == 8)) begin : g_bad_channels
        $error("fta_respdemux128: CHANNELS must be 2, 4 or 8");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fta_respdemux128: DEPTH must be a power of two in 2..16");
    end

    // Value presented on an output port with nothing to deliver.
    function automatic fta_cmd_response128_t idle_resp();
        fta_cmd_response128_t r;
        r     = '0;
        r.pri = 4'hF;
        return r;
    endfunction

    // Pointers live in 0..DEPTH-1 and wrap back to zero.
    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        logic [CW-1:0] r;
        if (p[AW-1:0] == AW'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + CW'(1);
        end
        return r;
    endfunction

    logic [SW-1:0]        sel;
    fta_cmd_response128_t push_data;

    // Decode the target port and normalise the handshake bits of the stored entry.
    always_comb begin
        sel             = resp_i.tid[SEL_LSB +: SW];
        push_data       = resp_i;
        push_data.ack   = 1'b1;
        push_data.stall = 1'b0;
        push_data.next  = 1'b0;
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_port
        fta_cmd_response128_t mem_reg [DEPTH];
        fta_cmd_response128_t head_reg, head_next;
        logic [CW-1:0]        wr_ptr_reg, wr_ptr_next;
        logic [CW-1:0]        rd_ptr_reg, rd_ptr_next;
        logic [CW-1:0]        count_reg, count_next;
        logic                 ovf_reg;
        logic                 push, pop, full, wr_en, drop;

        // FIFO control and the value the output register will hold next cycle.
        // An entry written into an empty FIFO becomes the head directly, since
        // the storage array is not yet updated on that edge.
        always_comb begin
            push        = resp_i.ack && (sel == SW'(gi));
            pop         = head_reg.ack && rdy_i[gi];
            full        = (count_reg == CW'(DEPTH));
            wr_en       = push && (!full || pop);
            drop        = push && full && !pop;
            wr_ptr_next = wr_en ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
            rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
            count_next  = count_reg + CW'(wr_en) - CW'(pop);
            head_next   = idle_resp();
            if (count_next != '0) begin
                if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
                    head_next = push_data;
                end else begin
                    head_next = mem_reg[rd_ptr_next[AW-1:0]];
                end
            end
        end

        // Entry storage; contents are meaningless until written, so no reset.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
            end
        end

        // Pointer, occupancy, output and sticky overflow state.
        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
                head_reg   <= idle_resp();
                ovf_reg    <= 1'b0;
            end else begin
                wr_ptr_reg <= wr_ptr_next;
                rd_ptr_reg <= rd_ptr_next;
                count_reg  <= count_next;
                head_reg   <= head_next;
                ovf_reg    <= ovf_reg | drop;
            end
        end

        assign resp_o[gi] = head_reg;
        assign ovf_o[gi]  = ovf_reg;

`ifdef FTA_RESPDEMUX_DROPCNT_EN
        logic [7:0] drop_cnt_reg;

        // Saturating count of responses lost to a full FIFO.
        always_ff @(posedge clk) begin
            if (!rst) begin
                drop_cnt_reg <= 8'h00;
            end else if (drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'h01;
            end
        end

        assign drop_cnt_o[gi] = drop_cnt_reg;
`else
        assign drop_cnt_o[gi] = 8'h00;
`endif
    end

endmodule
